// File: rtl/coeff_ctrl_pkg.sv
// rtl/coeff_ctrl_pkg.sv - shared types and constants for the coefficient load controller
// Optional macro COEFF_LOAD_SYMMETRIC_EN halves the load depth for symmetric prototypes.
package coeff_ctrl_pkg;

    localparam int N_TAP_DEF       = 72;
    localparam int COEFF_WIDTH_DEF = 20;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_SLOT = 2'd2,
        COMMIT    = 2'd3
    } ctrl_state_e;

    typedef logic signed [COEFF_WIDTH_DEF-1:0] coeff_t;

    // Number of independently loaded taps; the symmetric build mirrors the upper half.
    function automatic int load_depth(input int n_tap);
`ifdef COEFF_LOAD_SYMMETRIC_EN
        return n_tap / 2;
`else
        return n_tap;
`endif
    endfunction

endpackage

// File: rtl/coeff_shadow_bank.sv
// rtl/coeff_shadow_bank.sv - shadow coefficient registers, load mask and output mirror
// Optional macro COEFF_LOAD_SYMMETRIC_EN mirrors shadow[k] onto tap N_TAP-1-k.
module coeff_shadow_bank
    import coeff_ctrl_pkg::*;
#(
    parameter int N_TAP       = N_TAP_DEF,
    parameter int COEFF_WIDTH = COEFF_WIDTH_DEF,
    parameter int ADDR_WIDTH  = $clog2(N_TAP),
    parameter int LOAD_DEPTH  = load_depth(N_TAP)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [ADDR_WIDTH-1:0]        wr_addr,
    input  logic [COEFF_WIDTH-1:0]       wr_data,
    input  logic                         mask_clr,
    output logic                         mask_full,
    output logic [N_TAP*COEFF_WIDTH-1:0] bank_data
);

    logic [COEFF_WIDTH-1:0] shadow [LOAD_DEPTH];
    logic [LOAD_DEPTH-1:0]  mask;
    logic [LOAD_DEPTH-1:0]  hit;

    always_comb begin
        hit = '0;
        for (int i = 0; i < LOAD_DEPTH; i++) begin
            hit[i] = wr_en && (wr_addr == ADDR_WIDTH'(i));
        end
    end

    // Completeness includes the beat being written this cycle.
    assign mask_full = &(mask | hit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask <= '0;
            for (int i = 0; i < LOAD_DEPTH; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            mask <= mask_clr ? '0 : (mask | hit);
            for (int i = 0; i < LOAD_DEPTH; i++) begin
                if (hit[i]) begin
                    shadow[i] <= wr_data;
                end
            end
        end
    end

    for (genvar k = 0; k < N_TAP; k++) begin : g_out
`ifdef COEFF_LOAD_SYMMETRIC_EN
        localparam int SRC = (k < LOAD_DEPTH) ? k : N_TAP - 1 - k;
`else
        localparam int SRC = k;
`endif
        assign bank_data[k*COEFF_WIDTH +: COEFF_WIDTH] = shadow[SRC];
    end

endmodule

// File: rtl/coeff_load_ctrl.sv
// rtl/coeff_load_ctrl.sv - sequences staged coefficient loads into the decimator in a sample gap
// Optional macro COEFF_LOAD_SYMMETRIC_EN loads only the lower half of a symmetric filter.
module coeff_load_ctrl
    import coeff_ctrl_pkg::*;
#(
    parameter  int N_TAP       = N_TAP_DEF,
    parameter  int COEFF_WIDTH = COEFF_WIDTH_DEF,
    parameter  int TIMEOUT     = 1024,
    localparam int ADDR_WIDTH  = $clog2(N_TAP)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic [ADDR_WIDTH-1:0]        cfg_addr,
    input  logic [COEFF_WIDTH-1:0]       cfg_data,
    input  logic                         cfg_last,
    input  logic                         cfg_abort,
    input  logic                         filt_valid_in,
    output logic                         coeff_wr_en,
    output logic [N_TAP*COEFF_WIDTH-1:0] coeff_wr_data,
    input  logic [N_TAP*COEFF_WIDTH-1:0] coeff_live,
    input  logic                         rd_req,
    input  logic [ADDR_WIDTH-1:0]        rd_addr,
    output logic [COEFF_WIDTH-1:0]       rd_data,
    output logic                         rd_valid,
    output logic                         busy,
    output logic                         cfg_err,
    output logic                         commit_done,
    output logic                         commit_forced
);

    localparam int LOAD_DEPTH = load_depth(N_TAP);
    localparam int TW         = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_LOAD   = LOAD;
    localparam logic [1:0] S_WAIT   = WAIT_SLOT;
    localparam logic [1:0] S_COMMIT = COMMIT;

    logic [1:0]             state;
    logic [1:0]             state_nxt;
    logic [TW-1:0]          timer;
    logic                   beat;
    logic                   in_range;
    logic                   bank_wr;
    logic                   abort_act;
    logic                   in_wait;
    logic                   timeout_hit;
    logic                   mask_full;
    logic                   mask_clr;
    logic [COEFF_WIDTH-1:0] rd_sel;

    assign cfg_ready = (state == S_IDLE) || (state == S_LOAD);
    assign busy      = (state != S_IDLE);

    // An abort in the same cycle as a beat discards the beat.
    assign beat      = cfg_valid && cfg_ready && !cfg_abort;
    assign in_range  = 32'(cfg_addr) < 32'(LOAD_DEPTH);
    assign bank_wr   = beat && in_range;
    assign abort_act = cfg_abort && ((state == S_LOAD) || (state == S_WAIT));

    assign in_wait       = (state == S_WAIT) && !cfg_abort;
    assign timeout_hit   = (timer == TW'(TIMEOUT - 1));
    assign coeff_wr_en   = in_wait && (!filt_valid_in || timeout_hit);
    assign commit_forced = in_wait && filt_valid_in && timeout_hit;
    assign commit_done   = (state == S_COMMIT);

    assign cfg_err  = beat && (!in_range || (cfg_last && !mask_full));
    assign mask_clr = abort_act || commit_done || (bank_wr && cfg_last && !mask_full);

    coeff_shadow_bank #(
        .N_TAP       (N_TAP),
        .COEFF_WIDTH (COEFF_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .LOAD_DEPTH  (LOAD_DEPTH)
    ) u_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (bank_wr),
        .wr_addr   (cfg_addr),
        .wr_data   (cfg_data),
        .mask_clr  (mask_clr),
        .mask_full (mask_full),
        .bank_data (coeff_wr_data)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_LOAD: begin
                if (abort_act) begin
                    state_nxt = S_IDLE;
                end else if (bank_wr) begin
                    if (!cfg_last) begin
                        state_nxt = S_LOAD;
                    end else if (mask_full) begin
                        state_nxt = S_WAIT;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_WAIT: begin
                if (abort_act) begin
                    state_nxt = S_IDLE;
                end else if (coeff_wr_en) begin
                    state_nxt = S_COMMIT;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            timer <= '0;
        end else begin
            state <= state_nxt;
            if (abort_act || commit_done) begin
                timer <= '0;
            end else if (state == S_WAIT) begin
                timer <= timer + 1'b1;
            end
        end
    end

    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < N_TAP; i++) begin
            if (rd_addr == ADDR_WIDTH'(i)) begin
                rd_sel = coeff_live[i*COEFF_WIDTH +: COEFF_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) begin
                rd_data <= rd_sel;
            end
        end
    end

endmodule

// File: tb/tb_coeff_load_ctrl.sv
// tb/tb_coeff_load_ctrl.sv - directed self-checking bench for coeff_load_ctrl
// Honours COEFF_LOAD_SYMMETRIC_EN so the same vectors cover the mirrored build.
module tb_coeff_load_ctrl;

    localparam int N  = 72;
    localparam int W  = 20;
    localparam int AW = $clog2(N);
`ifdef COEFF_LOAD_SYMMETRIC_EN
    localparam int LD = N / 2;
`else
    localparam int LD = N;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           cfg_valid = 1'b0;
    logic           cfg_ready;
    logic [AW-1:0]  cfg_addr = '0;
    logic [W-1:0]   cfg_data = '0;
    logic           cfg_last = 1'b0;
    logic           cfg_abort = 1'b0;
    logic           filt_valid_in = 1'b0;
    logic           coeff_wr_en;
    logic [N*W-1:0] coeff_wr_data;
    logic [N*W-1:0] live = '0;
    logic           rd_req = 1'b0;
    logic [AW-1:0]  rd_addr = '0;
    logic [W-1:0]   rd_data;
    logic           rd_valid;
    logic           busy;
    logic           cfg_err;
    logic           commit_done;
    logic           commit_forced;

    int total = 0;
    int bad   = 0;
    int wr_cnt = 0, done_cnt = 0, frc_cnt = 0;
    int w0, d0, f0;

    coeff_load_ctrl #(
        .N_TAP       (N),
        .COEFF_WIDTH (W),
        .TIMEOUT     (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_addr      (cfg_addr),
        .cfg_data      (cfg_data),
        .cfg_last      (cfg_last),
        .cfg_abort     (cfg_abort),
        .filt_valid_in (filt_valid_in),
        .coeff_wr_en   (coeff_wr_en),
        .coeff_wr_data (coeff_wr_data),
        .coeff_live    (live),
        .rd_req        (rd_req),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .busy          (busy),
        .cfg_err       (cfg_err),
        .commit_done   (commit_done),
        .commit_forced (commit_forced)
    );

    always #5 clk = ~clk;

    // Stand-in decimator: captures the shadow bank on coeff_wr_en, ignores reset.
    always @(posedge clk) begin
        if (coeff_wr_en) live <= coeff_wr_data;
    end

    always @(negedge clk) begin
        #3;
        if (rst_n) begin
            wr_cnt   += int'(coeff_wr_en);
            done_cnt += int'(commit_done);
            frc_cnt  += int'(commit_forced);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int mir(input int k);
        return (k < LD) ? k : N - 1 - k;
    endfunction

    function automatic logic [31:0] wd(input int k);
        return 32'(coeff_wr_data[k*W +: W]);
    endfunction

    task automatic beat(input int a, input int d, input bit last);
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_addr  = AW'(a);
        cfg_data  = W'(d);
        cfg_last  = last;
        cfg_abort = 1'b0;
    endtask

    task automatic idle_cyc();
        @(negedge clk);
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
        cfg_abort = 1'b0;
    endtask

    task automatic load(input int lo, input int hi, input int base, input bit last);
        for (int a = lo; a < hi; a++) beat(a, base + a, last && (a == hi - 1));
    endtask

    task automatic read_chk(input string tag, input int a, input int exp);
        @(negedge clk);
        rd_req  = 1'b1;
        rd_addr = AW'(a);
        @(negedge clk);
        rd_req = 1'b0;
        #1;
        check({tag, "_valid"}, 32'(rd_valid), 1);
        check({tag, "_data"}, 32'(rd_data), 32'(exp));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_ready", 32'(cfg_ready), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_wr_en", 32'(coeff_wr_en), 0);
        check("rst_err", 32'(cfg_err), 0);
        check("rst_done", 32'(commit_done), 0);
        check("rst_rd_valid", 32'(rd_valid), 0);
        check("rst_bank_zero", 32'(coeff_wr_data == '0), 1);

        // Full load in a sample gap: data = addr*16
        w0 = wr_cnt; d0 = done_cnt; f0 = frc_cnt;
        for (int a = 0; a < LD; a++) beat(a, a * 16, a == LD - 1);
        idle_cyc(); #1;
        check("t1_wr_en", 32'(coeff_wr_en), 1);
        check("t1_ready_wait", 32'(cfg_ready), 0);
        idle_cyc(); #1;
        check("t1_done", 32'(commit_done), 1);
        check("t1_wr_en_off", 32'(coeff_wr_en), 0);
        idle_cyc(); #1;
        check("t1_idle", 32'(busy), 0);
        check("t1_wr_cnt", 32'(wr_cnt - w0), 1);
        check("t1_done_cnt", 32'(done_cnt - d0), 1);
        check("t1_frc_cnt", 32'(frc_cnt - f0), 0);
        check("t1_bank10", wd(10), 32'(mir(10) * 16));
        read_chk("t1_rd5", 5, 'h50);
        @(negedge clk); rd_req = 1'b1; rd_addr = AW'(71);
        @(negedge clk); rd_addr = AW'(100); #1;
        check("t1_rd71", 32'(rd_data), 32'(mir(71) * 16));
        @(negedge clk); rd_req = 1'b0; #1;
        check("t1_rd_oor", 32'(rd_data), 0);
        check("t1_rd_b2b_valid", 32'(rd_valid), 1);
        @(negedge clk); #1;
        check("t1_rd_valid_drop", 32'(rd_valid), 0);

        // Forced commit: filt_valid_in never drops, TIMEOUT = 8
        filt_valid_in = 1'b1;
        w0 = wr_cnt; f0 = frc_cnt;
        load(0, LD, 'h200, 1'b1);
        for (int c = 1; c <= 8; c++) begin
            idle_cyc(); #1;
            check($sformatf("t2_wr_en_c%0d", c), 32'(coeff_wr_en), 32'(c == 8));
            check($sformatf("t2_forced_c%0d", c), 32'(commit_forced), 32'(c == 8));
            check($sformatf("t2_ready_c%0d", c), 32'(cfg_ready), 0);
        end
        idle_cyc(); #1;
        check("t2_done", 32'(commit_done), 1);
        filt_valid_in = 1'b0;
        check("t2_wr_cnt", 32'(wr_cnt - w0), 1);
        check("t2_frc_cnt", 32'(frc_cnt - f0), 1);
        read_chk("t2_rd5", 5, 'h205);

        // Incomplete load closed by cfg_last on a rewrite
        w0 = wr_cnt;
        load(0, LD - 1, 'h300, 1'b0);
        beat(3, 'h3AA, 1'b1); #1;
        check("t3_err", 32'(cfg_err), 1);
        idle_cyc(); #1;
        check("t3_idle", 32'(busy), 0);
        check("t3_err_pulse", 32'(cfg_err), 0);
        check("t3_retained", wd(LD - 2), 32'('h300 + LD - 2));
        beat(LD - 1, 'h3FF, 1'b1); #1;
        check("t3_mask_cleared", 32'(cfg_err), 1);
        idle_cyc(); #1;
        check("t3_idle2", 32'(busy), 0);
        check("t3_no_wr", 32'(wr_cnt - w0), 0);

        // Out-of-range beat, then abort mid-load, then a clean load
        beat(80, 'h7FFFF, 1'b0); #1;
        check("t4_oor_err", 32'(cfg_err), 1);
        idle_cyc(); #1;
        check("t4_oor_idle", 32'(busy), 0);
        check("t4_shadow_kept", wd(8), 32'('h308));
        load(0, 10, 'h400, 1'b0);
        @(negedge clk); cfg_valid = 1'b0; cfg_abort = 1'b1; #1;
        check("t4_loading", 32'(busy), 1);
        idle_cyc(); #1;
        check("t4_aborted", 32'(busy), 0);
        w0 = wr_cnt;
        load(0, LD, 'h500, 1'b1);
        repeat (3) idle_cyc();
        #1;
        check("t4_reload_wr", 32'(wr_cnt - w0), 1);
        read_chk("t4_rd9", 9, 'h509);

        // Abort coinciding with the sample gap
        filt_valid_in = 1'b1;
        w0 = wr_cnt;
        load(0, LD, 'h600, 1'b1);
        idle_cyc(); #1;
        check("t5_wait_hold", 32'(coeff_wr_en), 0);
        @(negedge clk); filt_valid_in = 1'b0; cfg_abort = 1'b1; #1;
        check("t5_abort_wins", 32'(coeff_wr_en), 0);
        idle_cyc(); #1;
        check("t5_idle", 32'(busy), 0);
        check("t5_no_done", 32'(commit_done), 0);
        check("t5_no_wr", 32'(wr_cnt - w0), 0);
        read_chk("t5_rd5", 5, 'h505);
        check("t6_bank71", wd(71), 32'('h600 + mir(71)));
        check("t6_bank36", wd(36), 32'('h600 + mir(36)));

        // Asynchronous reset mid-load leaves the decimator untouched
        load(0, 5, 'h700, 1'b0);
        idle_cyc();
        #2 rst_n = 1'b0;
        #1;
        check("t7_rst_busy", 32'(busy), 0);
        check("t7_rst_ready", 32'(cfg_ready), 1);
        check("t7_rst_bank", wd(0), 0);
        @(negedge clk); rst_n = 1'b1;
        read_chk("t7_live_kept", 5, 'h505);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
